// File: rtl/md_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: 32-step shift-add multiply,
// restoring divide, one sign-fix cycle, then a one-cycle DONE with HI/LO live.
module md_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 is_div_q, is_div_d;
    logic                 sa_q, sa_d;
    logic                 sb_q, sb_d;
    logic                 dz_q, dz_d;
    logic                 busy_q, busy_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 signed_op;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift, div_diff;
    logic                 div_keep;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    // MULT (00) and DIV (10) are the signed forms.
    assign signed_op = ~op[0];
    assign mag_a     = (signed_op && opA[WIDTH-1]) ? (~opA + 1'b1) : opA;
    assign mag_b     = (signed_op && opB[WIDTH-1]) ? (~opB + 1'b1) : opB;

    // acc holds {partial product high, multiplier} during a multiply.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // acc holds {remainder, dividend/quotient} during a divide.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_keep  = (div_shift >= {1'b0, b_q});
    assign div_next  = div_keep ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    assign prod_fix = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
    assign quot_fix = (sa_q ^ sb_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign rem_fix  = sa_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    is_div_d = op[1];
                    sa_d     = signed_op & opA[WIDTH-1];
                    sb_d     = signed_op & opB[WIDTH-1];
                    cnt_d    = CNT_W'(WIDTH);
                    dz_d     = 1'b0;
                    state_d  = ST_CALC;
                    if (op[1]) begin
                        acc_d = {{WIDTH{1'b0}}, mag_a};
                        b_d   = mag_b;
                        if (opB == '0) begin
                            // Divide by zero skips iteration; keep the raw dividend as remainder.
                            dz_d    = 1'b1;
                            acc_d   = {{WIDTH{1'b0}}, opA};
                            cnt_d   = '0;
                            state_d = ST_FIX;
                        end
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, mag_b};
                        b_d   = mag_a;
                    end
                end else if (!start) begin
                    if (wr_hi) hi_d = wr_data;
                    if (wr_lo) lo_d = wr_data;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (dz_q) begin
                        hi_d = acc_q[WIDTH-1:0];
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Stall drops in DONE so the instruction leaves EX as HI/LO become valid.
    assign stall = ((state_q == ST_IDLE) && start) || (state_q == ST_CALC) || (state_q == ST_FIX);
    assign busy  = busy_q;
    assign done  = (state_q == ST_DONE);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed and random bench for md_sequencer: expected {hi,lo} pairs are queued
// at launch and compared when done is seen, with latency/stall/busy tracking.
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA, opB;
    logic        flush;
    logic        wr_hi, wr_lo;
    logic [31:0] wr_data;
    logic        stall, busy, done;
    logic [31:0] hi, lo;

    logic [63:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    md_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
        .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r64;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin r64 = sa * sb; return 64'(r64); end
            2'b01: begin u = {32'b0, a} * {32'b0, b}; return u; end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Launch one op, hold start while stalled, then compare against the queue head.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat);
        int cyc;
        bit stall_ok, busy_ok, seen;
        logic [63:0] exp;
        exp_q.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b1; op = o; opA = a; opB = b;
        #1;
        check({tag, "_stall_launch"}, 64'(stall), 64'd1);
        cyc = 0; stall_ok = 1'b1; busy_ok = 1'b1; seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            #1;
            if (done) seen = 1'b1;
            else begin
                if (!stall) stall_ok = 1'b0;
                if (!busy) busy_ok = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_stall_window"}, 64'(stall_ok), 64'd1);
        check({tag, "_busy_window"}, 64'(busy_ok), 64'd1);
        check({tag, "_stall_done"}, 64'(stall), 64'd0);
        exp = exp_q.pop_front();
        check({tag, "_hilo"}, {hi, lo}, exp);
        @(negedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_hilo_hold"}, {hi, lo}, exp);
    endtask

    initial begin
        bit done_seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b0; start = 1'b0; op = 2'b00; opA = '0; opB = '0;
        flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_flags", {61'd0, stall, busy, done}, 64'd0);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 34);
        check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 34);
        check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu", 2'b11, 32'd100, 32'd7, 34);
        check("divu_const", {hi, lo}, {32'd2, 32'd14});
        run_op("divu_zero", 2'b11, 32'd5, 32'd0, 2);
        check("divu_zero_const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34);
        check("div_ovf_const", {hi, lo}, {32'd0, 32'h8000_0000});

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (rb == 32'd0) rb = 32'd1;
            run_op("rand", ro, ra, rb, 34);
        end

        // MTLO 0 then MTHI 0x1234, each visible the next cycle.
        @(negedge clk); wr_lo = 1'b1; wr_data = 32'd0;
        @(negedge clk); wr_lo = 1'b0; wr_hi = 1'b1; wr_data = 32'h0000_1234;
        @(negedge clk); wr_hi = 1'b0;
        #1;
        check("mthi_mtlo", {hi, lo}, {32'h0000_1234, 32'd0});

        // Start with a simultaneous MTHI (write must drop), then flush at iteration 10.
        @(negedge clk);
        start = 1'b1; op = 2'b01; opA = 32'd2; opB = 32'd3; wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
        done_seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            wr_hi = 1'b0;
            #1;
            if (done) done_seen = 1'b1;
            if (k == 10) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_stall", 64'(stall), 64'd0);
        repeat (3) begin
            if (done) done_seen = 1'b1;
            @(negedge clk); #1;
        end
        check("flush_no_done", 64'(done_seen), 64'd0);
        check("flush_hilo", {hi, lo}, {32'h0000_1234, 32'd0});

        // Reset at iteration 20 of a DIVU.
        @(negedge clk);
        start = 1'b1; op = 2'b11; opA = 32'd1000; opB = 32'd3;
        repeat (20) @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_stall", 64'(stall), 64'd0);
        run_op("after_rst", 2'b01, 32'd6, 32'd7, 34);
        check("after_rst_const", {hi, lo}, 64'd42);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
Iterative multiply/divide sequencer that sits beside the execute stage and owns the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU operands from the execute-stage forwarded operand paths: operand A is the forwarded source-A value; operand B is the forwarded source-B value before the ALUSrc immediate mux. It runs a 32-iteration shift-add or restoring-divide sequence and holds the pipeline stall line high until HI/LO are valid. It also services MTHI/MTLO writes and presents HI/LO for MFHI/MFLO reads.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
start  input  1  execute stage holds a mult/div instruction this cycle
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
opA  input  WIDTH  forwarded source A (multiplicand / dividend)
opB  input  WIDTH  forwarded source B (multiplier / divisor)
flush  input  1  pipeline flush; abort the in-flight operation
wr_hi  input  1  MTHI write strobe
wr_lo  input  1  MTLO write strobe
wr_data  input  WIDTH  MTHI/MTLO data
stall  output  1  freeze IF/ID/EX; combinational
busy  output  1  registered; high in CALC or FIX
done  output  1  one-cycle pulse when HI/LO are updated by an operation
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0 at edge): state=IDLE; hi=0; lo=0; done=0; busy=0; counter=0. Reset mid-operation abandons the operation with no HI/LO update.
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 latches op, |opA|, |opB| and the sign bits. Magnitudes are taken only for MULT/DIV; MULTU/DIVU take operands unchanged. Counter is loaded with WIDTH and state goes to CALC.
  - DIV/DIVU with opB=0: go directly to FIX, no iterations.
- CALC: one iteration per cycle; counter decrements; at counter==1 the next state is FIX. CALC lasts exactly WIDTH cycles.
  - Multiply: 2*WIDTH-bit accumulator, right-shift add.
  - Divide: restoring. Remainder shifts left with the next dividend bit. Subtract the divisor and keep the result if it is non-negative; shift in quotient bit 1 when kept, 0 otherwise.
- FIX, one cycle: sign correction, then next state DONE.
  - MULT: negate the 64-bit product if signA^signB.
  - DIV: negate the quotient if signA^signB; negate the remainder if signA.
  - Divide-by-zero: quotient=all ones, remainder=opA as latched.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps).
- DONE, one cycle:
  - Multiply: hi=product[63:32], lo=product[31:0].
  - Divide: lo=quotient, hi=remainder.
  - done=1; next state IDLE.
- Latency: start sampled at edge N → done high in cycle N+WIDTH+2 (N+34). Divide-by-zero: N+2.
- stall = start (in IDLE) OR state in {CALC, FIX}. Stall drops in DONE, so the instruction advances in the same cycle HI/LO become visible. A dependent MFHI/MFLO the following cycle reads the new values.
- busy = registered (state in {CALC, FIX}).
- start while not IDLE: ignored. The pipeline is stalled, so start is held by the same instruction; no re-launch occurs.
- flush in any non-IDLE state: next state IDLE; HI/LO unchanged; no done pulse. flush together with start in IDLE: start ignored.
- wr_hi/wr_lo: honoured only in IDLE and only when start=0; write at the edge, visible the next cycle. While not IDLE they are dropped (the pipeline is stalled, so none legally arrive).
- Simultaneous wr_hi and start in IDLE: start wins; the write is dropped.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles hi=0xFFFFFFFE, lo=0x00000001, done for exactly 1 cycle, stall high cycles N..N+33.
- MULT −3 (0xFFFFFFFD) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV −7 / 2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); DIVU 100/7 → lo=14, hi=2.
- DIVU 5 / 0 → done at N+2, lo=0xFFFFFFFF, hi=5; then DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x1234 then start MULTU 2×3; assert flush at iteration 10 → state IDLE next cycle, no done, hi=0x1234, lo=0 preserved.
- Assert reset low at iteration 20 of a DIVU → next cycle hi=lo=0, busy=0, stall=0; new MULTU 6×7 then completes with lo=42.
